// File: rtl/issue_sched.sv
// issue_sched: scoreboard issue scheduler, one functional-unit status entry per FU.
// Each entry holds producer tags, wakes on writeback, ages while waiting, and the
// oldest ready entry issues through a registered issue port (one per cycle).
//
// Ports:
//   CLK, nRST      clock, asynchronous active-low reset
//   disp_*         dispatch request: target entry, NSRC producer tags, payload
//   disp_ready     per-entry acceptance (combinational from state and wb_valid)
//   wb_valid       per-FU writeback strobes (wake tags, free EX entries)
//   freeze         hold issue outputs and block selection
//   flush          squash all entries and drop the issue strobe
//   issue_*        registered issue strobe, entry index and payload
//   busy           per-entry "not EMPTY"
//   issued_cnt     issues counted (ISSUE_PERF_CNT_EN), else 0
//   stall_cnt      cycles with a ready entry but no issue (ISSUE_PERF_CNT_EN), else 0
//
// Optional feature macro: ISSUE_PERF_CNT_EN enables the two perf counters.
module issue_sched #(
  parameter int unsigned NUM_FU    = 5,
  parameter int unsigned NSRC      = 3,
  parameter int unsigned TAG_W     = 3,
  parameter int unsigned AGE_W     = 4,
  parameter int unsigned PAYLOAD_W = 64,
  localparam int unsigned FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  disp_valid,
  input  logic [FU_W-1:0]       disp_fu,
  input  logic [NSRC*TAG_W-1:0] disp_tags,
  input  logic [PAYLOAD_W-1:0]  disp_payload,
  output logic [NUM_FU-1:0]     disp_ready,
  input  logic [NUM_FU-1:0]     wb_valid,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  issue_valid,
  output logic [FU_W-1:0]       issue_fu,
  output logic [PAYLOAD_W-1:0]  issue_payload,
  output logic [NUM_FU-1:0]     busy,
  output logic [31:0]           issued_cnt,
  output logic [31:0]           stall_cnt
);

  typedef enum logic [1:0] {EMPTY, WAIT, RDY, EX} ent_state_t;

  ent_state_t            state_q   [NUM_FU];
  ent_state_t            state_d   [NUM_FU];
  logic [NSRC*TAG_W-1:0] tags_q    [NUM_FU];
  logic [NSRC*TAG_W-1:0] tags_d    [NUM_FU];
  logic [NSRC*TAG_W-1:0] tags_wk   [NUM_FU];
  logic [AGE_W-1:0]      age_q     [NUM_FU];
  logic [AGE_W-1:0]      age_d     [NUM_FU];
  logic [PAYLOAD_W-1:0]  payload_q [NUM_FU];
  logic [PAYLOAD_W-1:0]  payload_d [NUM_FU];

  logic [NSRC*TAG_W-1:0] disp_tags_wk;
  logic                  sel_valid;
  logic [FU_W-1:0]       sel_idx;
  logic [AGE_W-1:0]      sel_age;
  logic                  issue_go;

  // Clear every tag whose producer FU writes back this cycle (tag k <-> FU k-1).
  function automatic logic [NSRC*TAG_W-1:0] wake(input logic [NSRC*TAG_W-1:0] t,
                                                 input logic [NUM_FU-1:0]     wb);
    logic [NSRC*TAG_W-1:0] r;
    r = t;
    for (int unsigned s = 0; s < NSRC; s++) begin
      for (int unsigned k = 0; k < NUM_FU; k++) begin
        if (wb[k] && (t[s*TAG_W +: TAG_W] == TAG_W'(k + 1))) begin
          r[s*TAG_W +: TAG_W] = '0;
        end
      end
    end
    return r;
  endfunction

  // Oldest-ready-first: strict '>' keeps the lowest index on equal ages.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (state_q[i] == RDY && (!sel_valid || age_q[i] > sel_age)) begin
        sel_valid = 1'b1;
        sel_idx   = FU_W'(i);
        sel_age   = age_q[i];
      end
    end
  end

  assign issue_go = sel_valid && !freeze && !flush;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        state_q[i]   <= EMPTY;
        tags_q[i]    <= '0;
        age_q[i]     <= '0;
        payload_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        state_q[i]   <= state_d[i];
        tags_q[i]    <= tags_d[i];
        age_q[i]     <= age_d[i];
        payload_q[i] <= payload_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    disp_tags_wk = wake(disp_tags, wb_valid);
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      tags_wk[i]   = wake(tags_q[i], wb_valid);
      state_d[i]   = state_q[i];
      tags_d[i]    = tags_q[i];
      age_d[i]     = age_q[i];
      payload_d[i] = payload_q[i];
      if (flush) begin
        state_d[i] = EMPTY;
        age_d[i]   = '0;
      end else if (disp_valid && disp_fu == FU_W'(i) && disp_ready[i]) begin
        // Also covers EX freeing on this cycle's writeback: the new load wins.
        tags_d[i]    = disp_tags_wk;
        payload_d[i] = disp_payload;
        state_d[i]   = (disp_tags_wk == '0) ? RDY : WAIT;
        age_d[i]     = '0;
      end else begin
        case (state_q[i])
          WAIT, RDY: begin
            tags_d[i] = tags_wk[i];
            if (issue_go && sel_idx == FU_W'(i)) begin
              state_d[i] = EX;
              age_d[i]   = '0;
            end else begin
              state_d[i] = (tags_wk[i] == '0) ? RDY : WAIT;
              age_d[i]   = (age_q[i] == '1) ? age_q[i] : age_q[i] + AGE_W'(1);
            end
          end
          EX: begin
            age_d[i] = '0;
            if (wb_valid[i]) state_d[i] = EMPTY;
          end
          default: age_d[i] = '0;
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      disp_ready[i] = (state_q[i] == EMPTY) || (state_q[i] == EX && wb_valid[i]);
      busy[i]       = (state_q[i] != EMPTY);
    end
  end

  // Registered issue port; freeze holds everything including issue_valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      issue_valid   <= 1'b0;
      issue_fu      <= '0;
      issue_payload <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (!freeze) begin
      issue_valid <= sel_valid;
      if (sel_valid) begin
        issue_fu      <= sel_idx;
        issue_payload <= payload_q[sel_idx];
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic any_rdy;

  always_comb begin
    any_rdy = 1'b0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (state_q[i] == RDY) any_rdy = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      issued_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (issue_go) issued_cnt <= issued_cnt + 32'd1;
      if (any_rdy && !issue_go) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign issued_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_issue_sched.sv
module tb_issue_sched;
  logic        CLK;
  logic        nRST;
  logic        disp_valid;
  logic [2:0]  disp_fu;
  logic [8:0]  disp_tags;
  logic [63:0] disp_payload;
  logic [4:0]  disp_ready;
  logic [4:0]  wb_valid;
  logic        freeze;
  logic        flush;
  logic        issue_valid;
  logic [2:0]  issue_fu;
  logic [63:0] issue_payload;
  logic [4:0]  busy;
  logic [31:0] issued_cnt;
  logic [31:0] stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] stall_base;

  issue_sched #(
    .NUM_FU(5), .NSRC(3), .TAG_W(3), .AGE_W(4), .PAYLOAD_W(64)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_tags(disp_tags),
    .disp_payload(disp_payload), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .freeze(freeze), .flush(flush),
    .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_payload(issue_payload),
    .busy(busy), .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input logic [2:0] fu, input logic [8:0] tags, input logic [63:0] pl);
    disp_valid   = 1'b1;
    disp_fu      = fu;
    disp_tags    = tags;
    disp_payload = pl;
  endtask

  initial begin
    nRST = 1'b0; disp_valid = 1'b0; disp_fu = '0; disp_tags = '0; disp_payload = '0;
    wb_valid = '0; freeze = 1'b0; flush = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ivalid", 64'(issue_valid), 64'h0);
    check("rst_ifu", 64'(issue_fu), 64'h0);
    check("rst_ipayload", issue_payload, 64'h0);
    check("rst_dready", 64'(disp_ready), 64'h1F);
    check("rst_issued_cnt", 64'(issued_cnt), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    nRST = 1'b1;
    tick;

    // Ready dispatch
    disp(3'd2, 9'd0, 64'hA5);
    tick;
    disp_valid = 1'b0;
    check("rd_busy_t", 64'(busy), 64'h04);
    check("rd_ivalid_t", 64'(issue_valid), 64'h0);
    tick;
    check("rd_ivalid", 64'(issue_valid), 64'h1);
    check("rd_ifu", 64'(issue_fu), 64'h2);
    check("rd_ipayload", issue_payload, 64'hA5);
    check("rd_busy_ex", 64'(busy), 64'h04);
    check("rd_dready_ex", 64'(disp_ready), 64'h1B);
    tick;
    check("rd_ivalid_drop", 64'(issue_valid), 64'h0);
    check("rd_ifu_hold", 64'(issue_fu), 64'h2);
    wb_valid = 5'b00100;
    #1;
    check("rd_dready_wb", 64'(disp_ready), 64'h1F);
    tick;
    wb_valid = '0;
    check("rd_busy_free", 64'(busy), 64'h0);

    // Wakeup: entry 0 waits on FU1 (tag 2)
    disp(3'd0, 9'd2, 64'h0B);
    tick;
    disp_valid = 1'b0;
    check("wk_busy", 64'(busy), 64'h01);
    tick;
    check("wk_wait_noissue", 64'(issue_valid), 64'h0);
    wb_valid = 5'b00010;
    tick;
    wb_valid = '0;
    check("wk_rdy_noissue", 64'(issue_valid), 64'h0);
    tick;
    check("wk_ivalid", 64'(issue_valid), 64'h1);
    check("wk_ifu", 64'(issue_fu), 64'h0);
    check("wk_ipayload", issue_payload, 64'h0B);
    wb_valid = 5'b00001;
    tick;
    wb_valid = '0;

    // Oldest first: entry 3 age 4 vs entry 1 age 2
    freeze = 1'b1;
    disp(3'd3, 9'd0, 64'h33);
    tick;
    disp_valid = 1'b0;
    tick;
    disp(3'd1, 9'd0, 64'h11);
    tick;
    disp_valid = 1'b0;
    tick;
    tick;
    check("age_busy", 64'(busy), 64'h0A);
    check("age_frozen_ivalid", 64'(issue_valid), 64'h0);
    freeze = 1'b0;
    tick;
    check("age_first_fu", 64'(issue_fu), 64'h3);
    check("age_first_pl", issue_payload, 64'h33);
    tick;
    check("age_second_v", 64'(issue_valid), 64'h1);
    check("age_second_fu", 64'(issue_fu), 64'h1);
    check("age_second_pl", issue_payload, 64'h11);
    wb_valid = 5'b01010;
    tick;
    wb_valid = '0;
    check("age_free_busy", 64'(busy), 64'h0);

    // Equal (saturated) ages: lowest index first
    freeze = 1'b1;
    disp(3'd3, 9'd0, 64'h3E);
    tick;
    disp(3'd1, 9'd0, 64'h1E);
    tick;
    disp_valid = 1'b0;
    repeat (16) tick;
    freeze = 1'b0;
    tick;
    check("tie_first_fu", 64'(issue_fu), 64'h1);
    check("tie_first_pl", issue_payload, 64'h1E);
    tick;
    check("tie_second_fu", 64'(issue_fu), 64'h3);
    check("tie_second_pl", issue_payload, 64'h3E);
    wb_valid = 5'b01010;
    tick;
    wb_valid = '0;

    // Same-cycle free and dispatch on entry 1
    disp(3'd1, 9'd0, 64'h51);
    tick;
    disp_valid = 1'b0;
    tick;
    check("sc_issue_fu", 64'(issue_fu), 64'h1);
    wb_valid = 5'b00010;
    disp(3'd1, 9'd1, 64'h52);
    #1;
    check("sc_dready1", 64'(disp_ready[1]), 64'h1);
    tick;
    disp_valid = 1'b0;
    wb_valid = '0;
    check("sc_busy", 64'(busy), 64'h02);
    tick;
    check("sc_wait_noissue", 64'(issue_valid), 64'h0);
    wb_valid = 5'b00001;
    tick;
    wb_valid = '0;
    tick;
    check("sc_reissue_v", 64'(issue_valid), 64'h1);
    check("sc_reissue_pl", issue_payload, 64'h52);
    wb_valid = 5'b00010;
    tick;
    wb_valid = '0;

    // Freeze with an entry RDY, then flush with a dispatch pending
    disp(3'd4, 9'd0, 64'h44);
    tick;
    disp(3'd2, 9'd0, 64'h22);
    tick;
    disp_valid = 1'b0;
    freeze = 1'b1;
    stall_base = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("frz_ivalid", 64'(issue_valid), 64'h1);
      check("frz_ifu", 64'(issue_fu), 64'h4);
      check("frz_ipayload", issue_payload, 64'h44);
    end
    check("frz_busy", 64'(busy), 64'h14);
`ifdef ISSUE_PERF_CNT_EN
    check("frz_stall_delta", 64'(stall_cnt - stall_base), 64'h3);
`else
    check("frz_stall_zero", 64'(stall_cnt), 64'h0);
`endif
    freeze = 1'b0;
    flush = 1'b1;
    disp(3'd0, 9'd0, 64'h99);
    tick;
    flush = 1'b0;
    disp_valid = 1'b0;
    check("fl_busy", 64'(busy), 64'h0);
    check("fl_ivalid", 64'(issue_valid), 64'h0);
    tick;
    check("fl_busy_after", 64'(busy), 64'h0);
    check("fl_ivalid_after", 64'(issue_valid), 64'h0);

    // Reset mid-run with three entries busy
    disp(3'd0, 9'd0, 64'hC0);
    tick;
    disp(3'd1, 9'd0, 64'hC1);
    tick;
    disp(3'd2, 9'd0, 64'hC2);
    tick;
    disp_valid = 1'b0;
    check("mr_busy", 64'(busy), 64'h07);
    check("mr_ifu", 64'(issue_fu), 64'h1);
`ifdef ISSUE_PERF_CNT_EN
    check("mr_issued_cnt", 64'(issued_cnt), 64'd11);
`else
    check("mr_issued_zero", 64'(issued_cnt), 64'h0);
`endif
    #2;
    nRST = 1'b0;
    #1;
    check("mr_busy0", 64'(busy), 64'h0);
    check("mr_ivalid0", 64'(issue_valid), 64'h0);
    check("mr_ifu0", 64'(issue_fu), 64'h0);
    check("mr_ipayload0", issue_payload, 64'h0);
    check("mr_issued0", 64'(issued_cnt), 64'h0);
    check("mr_stall0", 64'(stall_cnt), 64'h0);
    check("mr_dready", 64'(disp_ready), 64'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
